// File: rtl/expr_stream_checker.sv
// Byte-serial recogniser for infix expressions with nested parentheses.
// It reports prefix validity, a sticky error, the nesting depth and per-';' verdicts.
module expr_stream_checker #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned MAX_DEPTH  = 7,
  parameter int unsigned DEPTH_W    = 3,
  parameter logic [3:0]  OP_MASK    = 4'b0011,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               done,
  output logic               done_ok,
  output logic [CNT_W-1:0]   ok_cnt
);

  typedef enum logic [1:0] {
    S_START,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_e;

  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [3:0]         NMAX = 4'(MAX_DIGITS);

  state_e             state_q, state_d;
  logic [3:0]         dig_q, dig_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               dok_q, dok_d;

  logic is_dig, is_op, is_lp, is_rp, is_semi;
  logic term;

  always_comb begin
    is_dig  = (in >= 8'h30) && (in <= 8'h39);
    is_op   = ((in == 8'h2B) && OP_MASK[0])
           || ((in == 8'h2A) && OP_MASK[1])
           || ((in == 8'h2D) && OP_MASK[2])
           || ((in == 8'h2F) && OP_MASK[3]);
    is_lp   = (in == 8'h28);
    is_rp   = (in == 8'h29);
    is_semi = (in == 8'h3B);
  end

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dok_d   = 1'b0;
    term    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        S_START: begin
          unique case (1'b1)
            is_dig: begin
              state_d = S_NUM;
              dig_d   = 4'd1;
            end
            is_lp: begin
              if (depth_q == DMAX) state_d = S_ERR;
              else depth_d = depth_q + DEPTH_W'(1);
            end
            is_semi: begin
              done_d  = 1'b1;
              depth_d = '0;
              dig_d   = '0;
            end
            default: state_d = S_ERR;
          endcase
        end
        S_NUM: begin
          unique case (1'b1)
            is_dig: begin
              if (dig_q == NMAX) state_d = S_ERR;
              else dig_d = dig_q + 4'd1;
            end
            is_op: state_d = S_START;
            is_rp: begin
              if (depth_q == '0) state_d = S_ERR;
              else begin
                depth_d = depth_q - DEPTH_W'(1);
                state_d = S_CLOSE;
              end
            end
            is_semi: term = 1'b1;
            default: state_d = S_ERR;
          endcase
        end
        S_CLOSE: begin
          unique case (1'b1)
            is_op: state_d = S_START;
            is_rp: begin
              if (depth_q == '0) state_d = S_ERR;
              else depth_d = depth_q - DEPTH_W'(1);
            end
            is_semi: term = 1'b1;
            default: state_d = S_ERR;
          endcase
        end
        default: begin
          if (is_semi) begin
            done_d  = 1'b1;
            state_d = S_START;
            depth_d = '0;
            dig_d   = '0;
          end
        end
      endcase
      if (term) begin
        done_d  = 1'b1;
        dok_d   = (depth_q == '0);
        state_d = S_START;
        depth_d = '0;
        dig_d   = '0;
        // saturate rather than wrap
        if ((depth_q == '0) && (cnt_q != '1))
          cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_START;
      dig_q   <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dok_q   <= dok_d;
    end
  end

  assign out     = ((state_q == S_NUM) || (state_q == S_CLOSE))
                && (depth_q == '0);
  assign err     = (state_q == S_ERR);
  assign depth   = depth_q;
  assign done    = done_q;
  assign done_ok = dok_q;
  assign ok_cnt  = cnt_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed bench for expr_stream_checker.
// Two instances share stimulus: default op set and one with '-' enabled.
module tb_expr_stream_checker;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in;

  logic       out0, err0, done0, dok0;
  logic [2:0] depth0;
  logic [7:0] cnt0;
  logic       out1, err1, done1, dok1;
  logic [2:0] depth1;
  logic [7:0] cnt1;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  expr_stream_checker u0 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out0), .err(err0), .depth(depth0),
    .done(done0), .done_ok(dok0), .ok_cnt(cnt0)
  );

  expr_stream_checker #(.OP_MASK(4'b0111)) u1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out1), .err(err1), .depth(depth1),
    .done(done1), .done_ok(dok1), .ok_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [7:0] o,
                     input logic [7:0] e);
    vecs++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  task automatic sendb(input byte b);
    in_valid = 1'b1;
    in       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sends(input string s);
    for (int i = 0; i < s.len(); i++) sendb(s[i]);
  endtask

  string s2;
  logic [2:0] d2 [13];
  logic       o2 [13];

  initial begin
    clr      = 1'b0;
    in_valid = 1'b0;
    in       = 8'h00;
    #12;
    chk("rst_out", 8'(out0), 8'd0);
    chk("rst_err", 8'(err0), 8'd0);
    chk("rst_depth", 8'(depth0), 8'd0);
    chk("rst_done", 8'(done0), 8'd0);
    chk("rst_dok", 8'(dok0), 8'd0);
    chk("rst_cnt", cnt0, 8'd0);
    @(negedge clk);
    clr = 1'b1;

    // "12+3*4;"
    sendb("1"); chk("t1_o1", 8'(out0), 8'd1);
    sendb("2"); chk("t1_o2", 8'(out0), 8'd1);
    sendb("+"); chk("t1_op", 8'(out0), 8'd0);
    sendb("3"); chk("t1_o3", 8'(out0), 8'd1);
    sendb("*"); chk("t1_ml", 8'(out0), 8'd0);
    sendb("4"); chk("t1_o4", 8'(out0), 8'd1);
    sendb(";");
    chk("t1_done", 8'(done0), 8'd1);
    chk("t1_dok", 8'(dok0), 8'd1);
    chk("t1_cnt", cnt0, 8'd1);
    chk("t1_out", 8'(out0), 8'd0);

    // "(1+(2*3))*45;"
    s2 = "(1+(2*3))*45;";
    d2 = '{1,1,1,2,2,2,2,1,0,0,0,0,0};
    o2 = '{0,0,0,0,0,0,0,0,1,0,1,1,0};
    for (int i = 0; i < 13; i++) begin
      sendb(s2[i]);
      chk($sformatf("t2_d%0d", i), 8'(depth0), 8'(d2[i]));
      chk($sformatf("t2_o%0d", i), 8'(out0), 8'(o2[i]));
    end
    chk("t2_dok", 8'(dok0), 8'd1);
    chk("t2_cnt", cnt0, 8'd2);

    // too many digits, then a good one
    sends("1234"); chk("t3_err4", 8'(err0), 8'd0);
    sendb("5"); chk("t3_err5", 8'(err0), 8'd1);
    sendb(";");
    chk("t3_done", 8'(done0), 8'd1);
    chk("t3_dok", 8'(dok0), 8'd0);
    chk("t3_errc", 8'(err0), 8'd0);
    sends("7;");
    chk("t3_dok2", 8'(dok0), 8'd1);
    chk("t3_cnt", cnt0, 8'd3);

    // '-' disabled on u0, enabled on u1
    sends("1-");
    chk("t4_err0", 8'(err0), 8'd1);
    chk("t4_err1", 8'(err1), 8'd0);
    sends("2;");
    chk("t4_dok0", 8'(dok0), 8'd0);
    chk("t4_dok1", 8'(dok1), 8'd1);
    chk("t4_cnt0", cnt0, 8'd3);
    chk("t4_cnt1", cnt1, 8'd4);

    // depth overflow
    sends("(((((((");
    chk("t5_d7", 8'(depth0), 8'd7);
    chk("t5_e7", 8'(err0), 8'd0);
    sendb("(");
    chk("t5_e8", 8'(err0), 8'd1);
    chk("t5_d8", 8'(depth0), 8'd7);
    sends("1))))))))");
    chk("t5_frz", 8'(depth0), 8'd7);
    sendb(";");
    chk("t5_dok", 8'(dok0), 8'd0);
    chk("t5_dep", 8'(depth0), 8'd0);
    // unmatched ')'
    sendb("1"); chk("t5_o1", 8'(out0), 8'd1);
    sendb(")"); chk("t5_rp", 8'(err0), 8'd1);
    sendb(";"); chk("t5_dk2", 8'(dok0), 8'd0);
    // unbalanced terminate
    sends("(1+2");
    chk("t5_d1", 8'(depth0), 8'd1);
    chk("t5_ob", 8'(out0), 8'd0);
    sendb(";");
    chk("t5_done3", 8'(done0), 8'd1);
    chk("t5_dk3", 8'(dok0), 8'd0);
    chk("t5_dz", 8'(depth0), 8'd0);
    chk("t5_cnt", cnt0, 8'd3);

    // in_valid gated with garbage in gaps
    sendb("3"); chk("t6_o1", 8'(out0), 8'd1);
    in_valid = 1'b0; in = "(";
    @(posedge clk); #1;
    chk("t6_g1", 8'(out0), 8'd1);
    chk("t6_gd", 8'(depth0), 8'd0);
    sendb("*"); chk("t6_o2", 8'(out0), 8'd0);
    in_valid = 1'b0; in = "x";
    @(posedge clk); #1;
    chk("t6_g2", 8'(out0), 8'd0);
    chk("t6_ge", 8'(err0), 8'd0);
    sendb("4"); chk("t6_o3", 8'(out0), 8'd1);
    in_valid = 1'b0; in = ";";
    @(posedge clk); #1;
    chk("t6_g3", 8'(out0), 8'd1);
    chk("t6_gdn", 8'(done0), 8'd0);
    sendb(";");
    chk("t6_done", 8'(done0), 8'd1);
    chk("t6_dok", 8'(dok0), 8'd1);
    chk("t6_cnt", cnt0, 8'd4);
    in_valid = 1'b0; in = "9";
    @(posedge clk); #1;
    chk("t6_dclr", 8'(done0), 8'd0);
    chk("t6_cnth", cnt0, 8'd4);

    // async reset mid-expression
    sendb("5");
    chk("t7_o", 8'(out0), 8'd1);
    in = "+";
    #2 clr = 1'b0;
    #1;
    chk("t7_out", 8'(out0), 8'd0);
    chk("t7_cnt", cnt0, 8'd0);
    chk("t7_cnt1", cnt1, 8'd0);
    chk("t7_err", 8'(err0), 8'd0);
    chk("t7_done", 8'(done0), 8'd0);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t7_nod", 8'(done0), 8'd0);
    chk("t7_out2", 8'(out0), 8'd0);
    chk("t7_dok", 8'(dok0), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/expr_stream_checker.md
# expr_stream_checker

Byte-serial recogniser for infix arithmetic expressions: multi-digit operands, a configurable operator set, nested parentheses and ';'-terminated back-to-back expressions. It sits on an 8-bit ASCII byte stream gated by a valid strobe. It reports per-byte prefix validity, a sticky error, the current nesting depth, a per-expression verdict, and a saturating count of accepted expressions.

## Interface
Parameters:
- MAX_DIGITS, 4, maximum digits per operand (1..15); leading zeros count as digits.
- MAX_DEPTH, 7, maximum parenthesis nesting; must fit in DEPTH_W.
- DEPTH_W, 3, width of the depth counter and port.
- OP_MASK, 4'b0011, enabled operators: bit0 '+', bit1 '*', bit2 '-', bit3 '/'. A disabled operator is an illegal byte.
- CNT_W, 8, width of ok_cnt.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset; asynchronous, active-low.
- in_valid  in  1  byte strobe; when low, all state holds.
- in  in  8  ASCII byte.
- out  out  1  bytes since last ';' form a complete, balanced expression.
- err  out  1  expression currently in error; sticky until ';' or reset.
- depth  out  DEPTH_W  current open-parenthesis count.
- done  out  1  one-cycle pulse: a ';' was consumed.
- done_ok  out  1  verdict for that ';'; valid only while done=1, 0 otherwise.
- ok_cnt  out  CNT_W  count of accepted expressions; saturates at all-ones.

## Operation
- Byte classes: digit '0'..'9'; op is an enabled operator; '(' ; ')' ; ';' ; other. "Other" includes space and disabled operators.
- States:
  - START: expecting an operand.
  - NUM: inside a number; digcnt holds the digit count.
  - CLOSE: just after ')'.
  - ERR: error.
- START:
  - digit: go to NUM, digcnt=1.
  - '(': if depth==MAX_DEPTH go to ERR; otherwise depth+1 and stay in START.
  - ';': done=1, done_ok=0, stay in START.
  - Anything else: go to ERR.
- NUM:
  - digit: if digcnt==MAX_DIGITS go to ERR; otherwise digcnt+1.
  - op: go to START.
  - ')': if depth==0 go to ERR; otherwise depth-1 and go to CLOSE.
  - ';': terminate (see below).
  - Anything else: go to ERR.
- CLOSE:
  - op: go to START.
  - ')': same rule as in NUM.
  - ';': terminate.
  - digit, '(' or other: go to ERR.
- Terminate (';' seen in NUM or CLOSE):
  - done=1, done_ok=(depth==0).
  - Go to START with depth=0 and digcnt=0.
  - If done_ok, ok_cnt+1, saturating.
- ERR:
  - ';': done=1, done_ok=0, go to START, depth=0.
  - Any other byte: stay in ERR; depth frozen.
- out = (state==NUM or CLOSE) and depth==0.
- err = (state==ERR).
- Unary operators are not supported; "-1" and "+1" at START go to ERR.

## Timing
- All outputs are registered. A byte accepted at edge k is reflected in out, err and depth after edge k.
- done and done_ok assert after the edge consuming ';' and clear after the next edge, regardless of in_valid.
- ok_cnt updates on the same edge that raises done.
- in_valid low: state, depth, digcnt and ok_cnt hold; done clears.
- Back-to-back ';' bytes each produce a done pulse: the first carries the verdict, later ones give done_ok=0 (empty expression).
- Reset values (clr low, immediate, asynchronous): state=START, digcnt=0, depth=0, out=0, err=0, done=0, done_ok=0, ok_cnt=0.
- Reset mid-expression discards it with no done pulse.
- ok_cnt saturation: at all-ones, further accepted expressions leave it unchanged; done_ok still reports 1.

## Test plan
- Defaults, "12+3*4;": out=1 after '1', '2', '3' and '4'; out=0 after '+' and '*'; done=1 and done_ok=1 the cycle after ';'; ok_cnt=1.
- Defaults, "(1+(2*3))*45;":
  - depth sequence 1,1,1,2,2,2,2,1,0,0,0,0,0.
  - out=1 only after the final ')' and after '4' and '5'.
  - done_ok=1.
- Defaults, "12345;" then "7;": err=1 after '5'; first done_ok=0; second done_ok=1; ok_cnt=1.
- OP_MASK=4'b0011, "1-2;": err=1 after '-', done_ok=0. Repeat with OP_MASK=4'b0111: done_ok=1.
- Defaults, eight '(' then "1" + eight ')' + ";": err=1 after the eighth '('. Also "1)" gives err=1 after ')', and "(1+2;" gives done_ok=0 with depth reset to 0.
- Stream "3*4" with in_valid toggling every other cycle and garbage on in while in_valid is low: result identical to the ungated case. Then drive clr low mid-"5+": all outputs become 0 immediately, ok_cnt=0, and there is no done pulse.
